// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the rotator and the vectoring engine.
// Holds the Q2.12 arctangent schedule, the coordinate/angle widths and the FSM state type.
package cordic_pkg;

   localparam int ITER = 12;
   localparam int XY_W = 16;
   localparam int Z_W  = 15;

   localparam logic signed [Z_W-1:0] HALF_PI_Q212 = 15'sd6434;

   // atan(2^-i) in Q2.12, one entry per micro-rotation
   localparam logic signed [Z_W-1:0] ATAN_Q212 [0:ITER-1] = '{
      15'sd3217, 15'sd1899, 15'sd1003, 15'sd509, 15'sd256, 15'sd128,
      15'sd64,   15'sd32,   15'sd16,   15'sd8,   15'sd4,   15'sd2
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_SCALE
   } cordic_state_e;

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent lookup for the CORDIC micro-rotation index.
// Indices beyond the table depth return zero.
module cordic_atan_lut
   import cordic_pkg::*;
(
   input  logic [3:0]     idx_i,
   output logic [Z_W-1:0] atan_o
);

   always_comb begin
      atan_o = '0;
      if (idx_i < 4'(ITER)) begin
         atan_o = ATAN_Q212[idx_i];
      end
   end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC in vectoring mode: Q0.7 (x, y) in, Q2.5 atan2 angle and Q1.7 magnitude out.
// One micro-rotation per cycle, then a shift-add gain compensation step.
module cordic_vector
   import cordic_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] angle,
   output logic [7:0] mag
);

   cordic_state_e          state_q, state_d;
   logic [3:0]             count_q, count_d;
   logic signed [XY_W-1:0] x_q, x_d, y_q, y_d;
   logic signed [Z_W-1:0]  z_q, z_d;
   logic                   zero_q, zero_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [7:0]             angle_q, angle_d;
   logic [7:0]             mag_q, mag_d;

   logic signed [XY_W-1:0] x_ext, y_ext, x_shr, y_shr;
   logic [Z_W-1:0]         atan_raw;
   logic signed [Z_W-1:0]  atan_step, z_rnd;
   logic signed [27:0]     x_wide, x_gain, x_rnd;
   logic signed [13:0]     mag_full;
   logic [7:0]             mag_sat, angle_val;

   cordic_atan_lut u_atan_lut (
      .idx_i  (count_q),
      .atan_o (atan_raw)
   );

   // Q0.7 inputs land in Q3.12; the spare integer bits let -128 negate cleanly
   assign x_ext     = {{3{x_in[7]}}, x_in, 5'b0};
   assign y_ext     = {{3{y_in[7]}}, y_in, 5'b0};
   assign x_shr     = x_q >>> count_q;
   assign y_shr     = y_q >>> count_q;
   assign atan_step = atan_raw;

   // Gain compensation x * 311/512, then round Q.21 down to Q1.7
   assign x_wide    = {{12{x_q[XY_W-1]}}, x_q};
   assign x_gain    = (x_wide <<< 8) + (x_wide <<< 6) - (x_wide <<< 3) - x_wide;
   assign x_rnd     = x_gain + 28'sd8192;
   assign mag_full  = 14'(x_rnd >>> 14);
   assign z_rnd     = z_q + 15'sd64;
   assign angle_val = 8'(z_rnd >>> 7);

   always_comb begin
      mag_sat = mag_full[7:0];
      if (mag_full[13]) begin
         mag_sat = '0;
      end else if (|mag_full[12:8]) begin
         mag_sat = 8'hFF;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      zero_d  = zero_q;
      angle_d = angle_q;
      mag_d   = mag_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               zero_d  = (x_in == 8'd0) && (y_in == 8'd0);
               count_d = '0;
               state_d = ST_ITER;
               // Fold the left half-plane into the right so the iterations converge
               if (!x_in[7]) begin
                  x_d = x_ext;
                  y_d = y_ext;
                  z_d = '0;
               end else if (!y_in[7]) begin
                  x_d = y_ext;
                  y_d = -x_ext;
                  z_d = HALF_PI_Q212;
               end else begin
                  x_d = -y_ext;
                  y_d = x_ext;
                  z_d = -HALF_PI_Q212;
               end
            end
         end
         ST_ITER: begin
            if (!y_q[XY_W-1]) begin
               x_d = x_q + y_shr;
               y_d = y_q - x_shr;
               z_d = z_q + atan_step;
            end else begin
               x_d = x_q - y_shr;
               y_d = y_q + x_shr;
               z_d = z_q - atan_step;
            end
            count_d = count_q + 4'd1;
            if (count_q == 4'(ITER - 1)) begin
               state_d = ST_SCALE;
            end
         end
         ST_SCALE: begin
            angle_d = zero_q ? 8'd0 : angle_val;
            mag_d   = zero_q ? 8'd0 : mag_sat;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign angle = angle_q;
   assign mag   = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed vectors, handshake timing,
// ignored restarts, mid-operation reset and a real-valued atan2/hypot sweep.
module tb_cordic_vector;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] xIn, yIn;
   logic       busy, done;
   logic [7:0] angle, mag;

   int testsRun  = 0;
   int failCount = 0;

   int    dirX    [6] = '{0, 64, -128, -64, 0, 127};
   int    dirY    [6] = '{64, 64, 0, -64, 0, 127};
   int    dirAng  [6] = '{50, 25, 101, -75, 0, 25};
   int    dirMag  [6] = '{64, 91, 128, 91, 0, 180};
   int    dirTol  [6] = '{1, 1, 1, 1, 0, 1};
   string dirName [6] = '{"y_axis", "diag_q1", "neg_x", "diag_q3", "zero", "sat_q1"};

   cordic_vector dut (
      .clk   (clock),
      .rst   (reset),
      .start (start),
      .x_in  (xIn),
      .y_in  (yIn),
      .busy  (busy),
      .done  (done),
      .angle (angle),
      .mag   (mag)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
      int diff;
      testsRun++;
      diff = observed - expected;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
      end
   endtask

   // Launch one operation and wait (bounded) for done; latency counts edges after acceptance
   task automatic applyStimulus(input int x, input int y, output int latency, output int busyEarly);
      @(negedge clock);
      xIn   = 8'(x);
      yIn   = 8'(y);
      start = 1'b1;
      @(negedge clock);
      start     = 1'b0;
      busyEarly = int'(busy);
      latency   = 0;
      while (!done && latency < 40) begin
         @(negedge clock);
         latency++;
      end
      if (!done) latency = -1;
   endtask

   initial begin
      int lat, busyEarly, doneCount, doneEdge, sawDone, nRand;
      int rx, ry, expAng, expMag;
      logic [7:0] rb;

      reset = 1'b1;
      start = 1'b0;
      xIn   = '0;
      yIn   = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset_busy",  int'(busy), 0, 0);
      checkOutput("reset_done",  int'(done), 0, 0);
      checkOutput("reset_angle", int'($signed(angle)), 0, 0);
      checkOutput("reset_mag",   int'(mag), 0, 0);
      reset = 1'b0;

      // Positive x axis plus full handshake timing
      applyStimulus(64, 0, lat, busyEarly);
      checkOutput("x_axis_busy_after_accept", busyEarly, 1, 0);
      checkOutput("x_axis_latency", lat, 13, 0);
      checkOutput("x_axis_busy_on_done", int'(busy), 1, 0);
      checkOutput("x_axis_angle", int'($signed(angle)), 0, 1);
      checkOutput("x_axis_mag", int'(mag), 64, 1);
      @(negedge clock);
      checkOutput("x_axis_done_pulse", int'(done), 0, 0);
      checkOutput("x_axis_busy_after", int'(busy), 0, 0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(dirX[i], dirY[i], lat, busyEarly);
         checkOutput({dirName[i], "_latency"}, lat, 13, 0);
         checkOutput({dirName[i], "_angle"}, int'($signed(angle)), dirAng[i], dirTol[i]);
         checkOutput({dirName[i], "_mag"}, int'(mag), dirMag[i], dirTol[i]);
      end

      // Start pulses at E3 and E13 carry a different vector and must be ignored
      @(negedge clock);
      xIn   = 8'd64;
      yIn   = 8'd64;
      start = 1'b1;
      doneCount = 0;
      doneEdge  = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clock);
         if (done) begin
            doneCount++;
            doneEdge = k - 1;
         end
         start = (k == 3) || (k == 13);
         xIn   = 8'h80;
         yIn   = 8'h00;
      end
      start = 1'b0;
      checkOutput("restart_done_count", doneCount, 1, 0);
      checkOutput("restart_done_edge", doneEdge, 13, 0);
      checkOutput("restart_angle", int'($signed(angle)), 25, 1);
      checkOutput("restart_mag", int'(mag), 91, 1);

      // Reset during iteration i=6 (edge E7) aborts and clears outputs
      @(negedge clock);
      xIn   = 8'd64;
      yIn   = 8'd0;
      start = 1'b1;
      sawDone = 0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         if (done) sawDone++;
         start = 1'b0;
         if (k == 7) reset = 1'b1;
      end
      @(negedge clock);
      reset = 1'b0;
      checkOutput("abort_no_done_before", sawDone, 0, 0);
      checkOutput("abort_done", int'(done), 0, 0);
      checkOutput("abort_busy", int'(busy), 0, 0);
      checkOutput("abort_angle", int'($signed(angle)), 0, 0);
      checkOutput("abort_mag", int'(mag), 0, 0);
      applyStimulus(0, 64, lat, busyEarly);
      checkOutput("post_abort_latency", lat, 13, 0);
      checkOutput("post_abort_angle", int'($signed(angle)), 50, 1);
      checkOutput("post_abort_mag", int'(mag), 64, 1);

      // Random sweep; very short vectors have an ill-conditioned angle and are skipped
      nRand = 0;
      while (nRand < 1000) begin
         rb = 8'($urandom_range(0, 255));
         rx = int'($signed(rb));
         rb = 8'($urandom_range(0, 255));
         ry = int'($signed(rb));
         if (rx * rx + ry * ry < 256) continue;
         expAng = int'($atan2(real'(ry), real'(rx)) * 32.0);
         expMag = int'($sqrt(real'(rx * rx + ry * ry)));
         applyStimulus(rx, ry, lat, busyEarly);
         checkOutput($sformatf("rand%0d_latency", nRand), lat, 13, 0);
         checkOutput($sformatf("rand%0d_angle(x=%0d,y=%0d)", nRand, rx, ry), int'($signed(angle)), expAng, 1);
         checkOutput($sformatf("rand%0d_mag(x=%0d,y=%0d)", nRand, rx, ry), int'(mag), expMag, 1);
         nRand++;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
